// File: rtl/seq_booth_mul.sv
// Multi-cycle radix-2 Booth signed multiplier with start/busy/done handshake.
// Define SEQ_BOOTH_MUL_UNSIGNED_EN to add the sgn port for unsigned operands.
module seq_booth_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef SEQ_BOOTH_MUL_UNSIGNED_EN
    input  logic               sgn,
`endif
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] y
);

    localparam int XW = WIDTH + 1;
    localparam int AW = WIDTH + 2;
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] acc;
    logic [AW-1:0] acc_nx;
    logic [XW-1:0] mcand;
    logic [XW-1:0] mcand_nx;
    logic [XW-1:0] mplr;
    logic [XW-1:0] mplr_nx;
    logic          q_m1;
    logic          q_m1_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [PW-1:0] y_nx;
    logic          done_nx;

    logic          sign_ext;
    logic [XW-1:0] a_ext;
    logic [XW-1:0] b_ext;
    logic [AW-1:0] mcand_sx;
    logic [AW-1:0] sum;

`ifdef SEQ_BOOTH_MUL_UNSIGNED_EN
    always_comb sign_ext = sgn;
`else
    always_comb sign_ext = 1'b1;
`endif

    always_comb begin
        a_ext    = {sign_ext & a[WIDTH-1], a};
        b_ext    = {sign_ext & b[WIDTH-1], b};
        mcand_sx = {mcand[XW-1], mcand};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        mcand_nx = mcand;
        mplr_nx  = mplr;
        q_m1_nx  = q_m1;
        cnt_nx   = cnt;
        y_nx     = y;
        done_nx  = 1'b0;
        sum      = acc;

        unique case (state)
            IDLE: begin
                if (start) begin
                    mcand_nx = a_ext;
                    mplr_nx  = b_ext;
                    acc_nx   = '0;
                    q_m1_nx  = 1'b0;
                    cnt_nx   = CW'(WIDTH + 1);
                    state_nx = CALC;
                end
            end
            CALC: begin
                unique case ({mplr[0], q_m1})
                    2'b01:   sum = acc + mcand_sx;
                    2'b10:   sum = acc - mcand_sx;
                    default: sum = acc;
                endcase
                // Arithmetic right shift of {acc, multiplier, q(-1)} as one word.
                acc_nx  = {sum[AW-1], sum[AW-1:1]};
                mplr_nx = {sum[0], mplr[XW-1:1]};
                q_m1_nx = mplr[0];
                cnt_nx  = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    y_nx     = {acc_nx[WIDTH-2:0], mplr_nx};
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            mcand <= '0;
            mplr  <= '0;
            q_m1  <= 1'b0;
            cnt   <= '0;
            y     <= '0;
            done  <= 1'b0;
        end else begin
            acc   <= acc_nx;
            mcand <= mcand_nx;
            mplr  <= mplr_nx;
            q_m1  <= q_m1_nx;
            cnt   <= cnt_nx;
            y     <= y_nx;
            done  <= done_nx;
        end
    end

    always_comb busy = (state == CALC);

endmodule

// File: tb/tb_seq_booth_mul.sv
// Directed and random checks of seq_booth_mul at WIDTH=8.
// Exercises the sgn port when SEQ_BOOTH_MUL_UNSIGNED_EN is defined.
module tb_seq_booth_mul;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
`ifdef SEQ_BOOTH_MUL_UNSIGNED_EN
    logic        sgn = 1'b1;
`endif
    logic        busy;
    logic        done;
    logic [15:0] y;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    seq_booth_mul #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SEQ_BOOTH_MUL_UNSIGNED_EN
        .sgn   (sgn),
`endif
        .busy  (busy),
        .done  (done),
        .y     (y)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] z, input logic s);
        logic signed [17:0] p;
        p = $signed({s & x[7], x}) * $signed({s & z[7], z});
        return p[15:0];
    endfunction

    // Caller is idle, 1 time unit after a rising edge.
    task automatic run_op(input string tag, input logic [7:0] xa, input logic [7:0] xb,
                          input logic [15:0] exp);
        int unsigned n;
        int unsigned busy_cyc;
        a = xa;
        b = xb;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, ".busy_on"}, 32'(busy), 32'd1);
        n = 0;
        busy_cyc = 1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                n = i;
                break;
            end
            if (busy) busy_cyc++;
        end
        check({tag, ".latency"}, 32'(n), 32'd9);
        check({tag, ".busy_cycles"}, 32'(busy_cyc), 32'd9);
        check({tag, ".y"}, 32'(y), 32'(exp));
        check({tag, ".busy_off"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
        check({tag, ".y_hold"}, 32'(y), 32'(exp));
    endtask

    initial begin
        int unsigned ndone;
        int unsigned d1;
        int unsigned d2;
        logic [15:0] y1;
        logic [15:0] y2;
        logic [7:0]  ra;
        logic [7:0]  rb;

        #3;
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.y", 32'(y), 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("basic", 8'd7, 8'hFD, 16'hFFEB);
        run_op("minmin", 8'h80, 8'h80, 16'h4000);
        run_op("minmax", 8'h80, 8'h7F, 16'hC080);
        run_op("zero", 8'h00, 8'hB3, 16'h0000);
        run_op("one_neg1", 8'h01, 8'hFF, 16'hFFFF);
        run_op("maxmax", 8'h7F, 8'h7F, 16'h3F01);

        // Start pulse while busy must be ignored.
        a = 8'd5; b = 8'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0; d1 = 0; y1 = '0;
        for (int i = 1; i <= 15; i++) begin
            @(posedge clk); #1;
            if (i == 3) begin a = 8'd9; b = 8'd9; start = 1'b1; end
            if (i == 4) start = 1'b0;
            if (done) begin ndone++; d1 = i; y1 = y; end
        end
        check("busyprot.ndone", 32'(ndone), 32'd1);
        check("busyprot.when", 32'(d1), 32'd9);
        check("busyprot.y", 32'(y1), 32'd30);
        check("busyprot.idle", 32'(busy), 32'd0);

        // Back-to-back with start held high.
        a = 8'd3; b = 8'd4; start = 1'b1;
        @(posedge clk); #1;
        a = 8'hFE; b = 8'hFE;
        ndone = 0; d1 = 0; d2 = 0; y1 = '0; y2 = '0;
        for (int i = 1; i <= 25; i++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (ndone == 1) begin d1 = i; y1 = y; end
                else begin d2 = i; y2 = y; start = 1'b0; break; end
            end
        end
        check("b2b.ndone", 32'(ndone), 32'd2);
        check("b2b.first_at", 32'(d1), 32'd9);
        check("b2b.second_at", 32'(d2), 32'd19);
        check("b2b.y1", 32'(y1), 32'd12);
        check("b2b.y2", 32'(y2), 32'd4);
        @(posedge clk); #1;
        check("b2b.idle", 32'(busy), 32'd0);

        // Asynchronous reset mid-operation.
        a = 8'd10; b = 8'd10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.done", 32'(done), 32'd0);
        check("midrst.y", 32'(y), 32'd0);
        #2 rst_n = 1'b1;
        ndone = 0;
        for (int i = 1; i <= 15; i++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        check("midrst.quiet", 32'(ndone), 32'd0);
        run_op("after_rst", 8'd10, 8'd10, 16'd100);

`ifdef SEQ_BOOTH_MUL_UNSIGNED_EN
        sgn = 1'b0;
        run_op("uns_ffxff", 8'hFF, 8'hFF, 16'hFE01);
        sgn = 1'b1;
        run_op("sgn_ffxff", 8'hFF, 8'hFF, 16'h0001);
        for (int m = 0; m < 2; m++) begin
            sgn = (m == 1);
            for (int k = 0; k < 1000; k++) begin
                ra = 8'($urandom);
                rb = 8'($urandom);
                run_op(sgn ? "rand_s" : "rand_u", ra, rb, ref_mul(ra, rb, sgn));
            end
        end
`else
        for (int k = 0; k < 1000; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op("rand", ra, rb, ref_mul(ra, rb, 1'b1));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
